regbank_arbiter: RTL and testbench
==================================

Name: regbank_arbiter

Overview:
- Shares the single-ported 8x16 register bank between two requesters: 0 = execute unit, 1 = stack spill/debug port.
- Sequences multi-cycle register operations (move, swap) over the bank's one select/load port.
- Drives the bank's rId/rIn/ldR inputs and samples its combinational rOut.
- Round-robin arbitration with valid/ready request and single-pulse response.

Parameters:
- DATA_W, 16, register/data width
- ID_W, 3, register select width (2**ID_W registers)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  2  per-requester request valid (bit k = requester k)
- req_ready  out  2  per-requester ready; request accepted on valid&ready at a rising edge
- req0_op / req1_op  in  2 each  00 read, 01 write, 10 move (ra<=rb), 11 swap (ra<->rb)
- req0_ra / req1_ra  in  ID_W each  primary register id
- req0_rb / req1_rb  in  ID_W each  secondary register id (move/swap only)
- req0_wdata / req1_wdata  in  DATA_W each  write data (write only)
- resp_valid  out  2  one-cycle completion pulse to the requester that issued the op
- resp_rdata  out  DATA_W  response data, valid while any resp_valid bit is high
- busy  out  1  high whenever state != IDLE
- rId  out  ID_W  to bank select
- rIn  out  DATA_W  to bank write data
- ldR  out  1  to bank load enable
- rOut  in  DATA_W  from bank read data (combinational on rId)

Behaviour:
- Reset (reset==0 at edge):
  - state IDLE; ldR=0; rId=0; rIn=0; resp_valid=0; resp_rdata=0.
  - Temporaries tmpA/tmpB cleared.
  - RR pointer set so requester 0 wins the first conflict.
- Reset mid-operation: the op is aborted immediately. No further ldR pulses, no resp_valid for it. Writes already completed stay in the bank.
- Arbitration:
  - req_ready is nonzero only in IDLE, and at most one bit is set.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last is granted. The pointer updates only on acceptance.
  - req_ready is combinational from state, req_valid and pointer.
  - Accepted op/ra/rb/wdata are latched at the accept edge; requester inputs are don't-care afterwards.
- FSM states: IDLE, RD, WR, MV_RD, MV_WR, SW_RA, SW_RB, SW_WA, SW_WB.
  - IDLE -> first state of the accepted op.
  - Bank outputs are driven from registered state in the cycle after accept.
- Per-op sequence (ldR=0 unless stated):
  - read: RD: rId=ra, rOut captured into resp_rdata. Op cycles 1.
  - write: WR: rId=ra, rIn=wdata, ldR=1. resp_rdata=wdata. Op cycles 1.
  - move: MV_RD: rId=rb, tmpA<=rOut. MV_WR: rId=ra, rIn=tmpA, ldR=1. resp_rdata=tmpA. Op cycles 2.
  - swap: SW_RA: rId=ra, tmpA<=rOut. SW_RB: rId=rb, tmpB<=rOut. SW_WA: rId=ra, rIn=tmpB, ldR=1. SW_WB: rId=rb, rIn=tmpA, ldR=1. resp_rdata=tmpA (old ra). Op cycles 4.
- Completion:
  - The last op state returns to IDLE.
  - resp_valid[k] is high for exactly the one cycle after the last op state (the first IDLE cycle).
  - A new request may be accepted in that same cycle.
  - Throughput: one read/write every 2 cycles.
- In IDLE: rId=0, rIn=0, ldR=0. ldR never asserts outside WR/MV_WR/SW_WA/SW_WB.
- ra==rb:
  - Move and swap still run the full sequence, and each ldR writes the same value back.
  - Register contents are unchanged.
  - resp_rdata = the register value.
- No back-pressure on resp: resp_valid is not held, and the requester must sample it.

Test Plan:
- Reset then req0 write ra=3 wdata=16'hBEEF, then req0 read ra=3 -> ldR pulses once with rId=3; read gives resp_valid[0] pulse with resp_rdata=16'hBEEF; reads of all other regs return 0.
- Regs 1=16'h1111, 2=16'h2222; req1 swap ra=1 rb=2 -> exactly 4 busy cycles, two ldR pulses (rId=1 rIn=2222, then rId=2 rIn=1111), resp_rdata=16'h1111; subsequent reads give 1=2222, 2=1111.
- Both requesters hold valid writes continuously -> grants alternate 0,1,0,1 starting with 0 after reset; neither requester is starved.
- req0 move ra=5 rb=5 with reg5=16'h00A5 -> one ldR with rIn=00A5, reg5 unchanged, resp_rdata=16'h00A5.
- Assert reset low during SW_RB of a swap -> next edge ldR=0, no resp_valid, busy=0; bank regs hold their pre-swap values.
- req_valid=2'b01 held while busy -> req_ready stays 0 until IDLE; request accepted the cycle resp_valid of the prior op pulses.

Source files
------------

// File: rtl/regbank_arbiter.sv
// Two-requester round-robin front end for the single-ported 8x16 register bank.
// Sequences read/write/move/swap over the bank's one select/load port.
//
// state | meaning
// IDLE  | no op in flight; arbitrate and accept one request
// RD    | select ra, capture rOut as response
// WR    | select ra, load wdata
// MV_RD | select rb, capture into tmpA
// MV_WR | select ra, load tmpA
// SW_RA | select ra, capture into tmpA
// SW_RB | select rb, capture into tmpB
// SW_WA | select ra, load tmpB
// SW_WB | select rb, load tmpA
module regbank_arbiter #(
   parameter int DATA_W = 16,
   parameter int ID_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [1:0]        req0_op,
   input  logic [1:0]        req1_op,
   input  logic [ID_W-1:0]   req0_ra,
   input  logic [ID_W-1:0]   req1_ra,
   input  logic [ID_W-1:0]   req0_rb,
   input  logic [ID_W-1:0]   req1_rb,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic [1:0]        resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              busy,
   output logic [ID_W-1:0]   rId,
   output logic [DATA_W-1:0] rIn,
   output logic              ldR,
   input  logic [DATA_W-1:0] rOut
);

   typedef enum logic [3:0] {
      IDLE, RD, WR, MV_RD, MV_WR, SW_RA, SW_RB, SW_WA, SW_WB
   } state_t;

   localparam logic [1:0] OP_RD = 2'b00;
   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] OP_MV = 2'b10;
   localparam logic [1:0] OP_SW = 2'b11;

   state_t              state;
   logic                last_grant;
   logic                owner;
   logic [ID_W-1:0]     ra_q;
   logic [ID_W-1:0]     rb_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   tmp_a;
   logic [DATA_W-1:0]   tmp_b;

   logic                accept;
   logic                sel;
   logic [1:0]          op_in;
   logic [ID_W-1:0]     ra_in;
   logic [ID_W-1:0]     rb_in;
   logic [DATA_W-1:0]   wdata_in;

   // On a conflict the requester that did not win last time is granted.
   always_comb begin
      req_ready = 2'b00;
      if (state == IDLE) begin
         case (req_valid)
            2'b01:   req_ready = 2'b01;
            2'b10:   req_ready = 2'b10;
            2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
            default: req_ready = 2'b00;
         endcase
      end
   end

   assign accept   = |req_ready;
   assign sel      = req_ready[1];
   assign op_in    = sel ? req1_op    : req0_op;
   assign ra_in    = sel ? req1_ra    : req0_ra;
   assign rb_in    = sel ? req1_rb    : req0_rb;
   assign wdata_in = sel ? req1_wdata : req0_wdata;

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         ra_q       <= '0;
         rb_q       <= '0;
         wdata_q    <= '0;
         tmp_a      <= '0;
         tmp_b      <= '0;
         rId        <= '0;
         rIn        <= '0;
         ldR        <= 1'b0;
         resp_valid <= 2'b00;
         resp_rdata <= '0;
      end else begin
         rId        <= '0;
         rIn        <= '0;
         ldR        <= 1'b0;
         resp_valid <= 2'b00;
         case (state)
            IDLE: begin
               if (accept) begin
                  last_grant <= sel;
                  owner      <= sel;
                  ra_q       <= ra_in;
                  rb_q       <= rb_in;
                  wdata_q    <= wdata_in;
                  case (op_in)
                     OP_RD: begin
                        state <= RD;
                        rId   <= ra_in;
                     end
                     OP_WR: begin
                        state <= WR;
                        rId   <= ra_in;
                        rIn   <= wdata_in;
                        ldR   <= 1'b1;
                     end
                     OP_MV: begin
                        state <= MV_RD;
                        rId   <= rb_in;
                     end
                     default: begin
                        state <= SW_RA;
                        rId   <= ra_in;
                     end
                  endcase
               end
            end
            RD: begin
               resp_rdata <= rOut;
               resp_valid <= owner ? 2'b10 : 2'b01;
               state      <= IDLE;
            end
            WR: begin
               resp_rdata <= wdata_q;
               resp_valid <= owner ? 2'b10 : 2'b01;
               state      <= IDLE;
            end
            // The value read this cycle is forwarded straight onto rIn for the load cycle.
            MV_RD: begin
               tmp_a <= rOut;
               state <= MV_WR;
               rId   <= ra_q;
               rIn   <= rOut;
               ldR   <= 1'b1;
            end
            MV_WR: begin
               resp_rdata <= tmp_a;
               resp_valid <= owner ? 2'b10 : 2'b01;
               state      <= IDLE;
            end
            SW_RA: begin
               tmp_a <= rOut;
               state <= SW_RB;
               rId   <= rb_q;
            end
            SW_RB: begin
               tmp_b <= rOut;
               state <= SW_WA;
               rId   <= ra_q;
               rIn   <= rOut;
               ldR   <= 1'b1;
            end
            SW_WA: begin
               state <= SW_WB;
               rId   <= rb_q;
               rIn   <= tmp_a;
               ldR   <= 1'b1;
            end
            SW_WB: begin
               resp_rdata <= tmp_a;
               resp_valid <= owner ? 2'b10 : 2'b01;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: behavioural bank, register-level reference model,
// directed scenarios plus randomized ops.
module tb_regbank_arbiter;
   localparam int DW = 16;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [1:0]    req0_op, req1_op;
   logic [IW-1:0] req0_ra, req1_ra, req0_rb, req1_rb;
   logic [DW-1:0] req0_wdata, req1_wdata;
   logic [1:0]    resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          busy;
   logic [IW-1:0] rId;
   logic [DW-1:0] rIn;
   logic          ldR;
   logic [DW-1:0] rOut;

   always #5 clk = ~clk;

   regbank_arbiter #(.DATA_W(DW), .ID_W(IW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req0_op(req0_op), .req1_op(req1_op), .req0_ra(req0_ra), .req1_ra(req1_ra),
      .req0_rb(req0_rb), .req1_rb(req1_rb), .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
      .rId(rId), .rIn(rIn), .ldR(ldR), .rOut(rOut)
   );

   // Bank: combinational read, load on rising edge.
   logic [DW-1:0] bank [8];
   assign rOut = bank[rId];
   always @(posedge clk) if (ldR) bank[rId] <= rIn;

   logic [DW-1:0] model [8];
   int lat_tab [4] = '{1, 1, 2, 4};
   int ld_tab  [4] = '{0, 1, 1, 2};

   int tests = 0;
   int fails = 0;

   logic          obs_done;
   int            obs_lat;
   int            obs_nld;
   logic [IW-1:0] obs_id  [4];
   logic [DW-1:0] obs_val [4];
   logic [DW-1:0] obs_rdata;
   logic [1:0]    obs_resp;
   logic          obs_idle_ok;

   task automatic set_req(input logic k, input logic [1:0] op, input logic [IW-1:0] ra,
                          input logic [IW-1:0] rb, input logic [DW-1:0] wd);
      if (k) begin
         req1_op = op; req1_ra = ra; req1_rb = rb; req1_wdata = wd;
      end else begin
         req0_op = op; req0_ra = ra; req0_rb = rb; req0_wdata = wd;
      end
   endtask

   task automatic scramble(input logic k);
      set_req(k, 2'($urandom_range(3)), 3'($urandom_range(7)), 3'($urandom_range(7)), 16'($urandom));
   endtask

   task automatic model_op(input logic [1:0] op, input logic [IW-1:0] ra, input logic [IW-1:0] rb,
                           input logic [DW-1:0] wd, output logic [DW-1:0] exp_rdata);
      logic [DW-1:0] t;
      case (op)
         2'b00: exp_rdata = model[ra];
         2'b01: begin model[ra] = wd; exp_rdata = wd; end
         2'b10: begin exp_rdata = model[rb]; model[ra] = model[rb]; end
         default: begin
            exp_rdata = model[ra];
            t = model[ra]; model[ra] = model[rb]; model[rb] = t;
         end
      endcase
   endtask

   // Issues one request from requester k and records what the bank port and response did.
   task automatic run_op(input logic k, input logic [1:0] op, input logic [IW-1:0] ra,
                         input logic [IW-1:0] rb, input logic [DW-1:0] wd);
      int n;
      obs_done = 1'b0; obs_lat = 0; obs_nld = 0; obs_resp = 2'b00;
      obs_rdata = '0; obs_idle_ok = 1'b0;
      @(negedge clk);
      set_req(k, op, ra, rb, wd);
      req_valid[k] = 1'b1;
      n = 0;
      while (!req_ready[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[k]) begin
         req_valid[k] = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid[k] = 1'b0;
      scramble(k);
      for (int c = 0; c < 20; c++) begin
         if (resp_valid != 2'b00) begin
            obs_done    = 1'b1;
            obs_resp    = resp_valid;
            obs_rdata   = resp_rdata;
            obs_idle_ok = (rId == '0) && (rIn == '0) && !ldR && !busy;
            break;
         end
         if (busy) obs_lat++;
         if (ldR) begin
            if (obs_nld < 4) begin
               obs_id[obs_nld[1:0]]  = rId;
               obs_val[obs_nld[1:0]] = rIn;
            end
            obs_nld++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      req_valid = 2'b00;
      set_req(1'b0, 2'b00, '0, '0, '0);
      set_req(1'b1, 2'b00, '0, '0, '0);
      repeat (3) @(negedge clk);
      tests++; if (ldR !== 1'b0) begin fails++; $display("FAIL reset_ldR got %b exp 0", ldR); end
      tests++; if (rId !== '0) begin fails++; $display("FAIL reset_rId got %h exp 0", rId); end
      tests++; if (rIn !== '0) begin fails++; $display("FAIL reset_rIn got %h exp 0", rIn); end
      tests++; if (resp_valid !== 2'b00) begin fails++; $display("FAIL reset_resp_valid got %b exp 00", resp_valid); end
      tests++; if (resp_rdata !== '0) begin fails++; $display("FAIL reset_resp_rdata got %h exp 0", resp_rdata); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready_idle got %b exp 00", req_ready); end
      req_valid = 2'b11;
      #1;
      tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL reset_ready_conflict got %b exp 01", req_ready); end
      req_valid = 2'b00;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_write_read;
      logic [DW-1:0] e;
      run_op(1'b0, 2'b01, 3'd3, 3'd0, 16'hBEEF);
      model_op(2'b01, 3'd3, 3'd0, 16'hBEEF, e);
      tests++; if (!obs_done || obs_resp !== 2'b01) begin fails++; $display("FAIL wr_resp got %b exp 01", obs_resp); end
      tests++; if (obs_nld != 1 || obs_id[0] !== 3'd3 || obs_val[0] !== 16'hBEEF) begin
         fails++; $display("FAIL wr_ldR got n=%0d id=%0d val=%h exp n=1 id=3 val=beef", obs_nld, obs_id[0], obs_val[0]); end
      tests++; if (obs_lat != 1) begin fails++; $display("FAIL wr_busy got %0d exp 1", obs_lat); end
      run_op(1'b0, 2'b00, 3'd3, 3'd0, 16'h0);
      tests++; if (!obs_done || obs_resp !== 2'b01 || obs_rdata !== 16'hBEEF) begin
         fails++; $display("FAIL rd3 got resp=%b data=%h exp 01 beef", obs_resp, obs_rdata); end
      tests++; if (obs_nld != 0 || obs_lat != 1) begin fails++; $display("FAIL rd3_timing got n=%0d lat=%0d exp 0 1", obs_nld, obs_lat); end
      for (int i = 0; i < 8; i++) begin
         if (i == 3) continue;
         run_op(1'($urandom_range(1)), 2'b00, 3'(i), 3'd0, 16'h0);
         model_op(2'b00, 3'(i), 3'd0, 16'h0, e);
         tests++; if (!obs_done || obs_rdata !== e) begin
            fails++; $display("FAIL rd_other r%0d got %h exp %h", i, obs_rdata, e); end
      end
   endtask

   task automatic test_swap;
      logic [DW-1:0] e;
      run_op(1'b1, 2'b01, 3'd1, 3'd0, 16'h1111); model_op(2'b01, 3'd1, 3'd0, 16'h1111, e);
      run_op(1'b1, 2'b01, 3'd2, 3'd0, 16'h2222); model_op(2'b01, 3'd2, 3'd0, 16'h2222, e);
      run_op(1'b1, 2'b11, 3'd1, 3'd2, 16'h0);    model_op(2'b11, 3'd1, 3'd2, 16'h0, e);
      tests++; if (obs_lat != 4) begin fails++; $display("FAIL swap_busy got %0d exp 4", obs_lat); end
      tests++; if (obs_nld != 2 || obs_id[0] !== 3'd1 || obs_val[0] !== 16'h2222 ||
                   obs_id[1] !== 3'd2 || obs_val[1] !== 16'h1111) begin
         fails++; $display("FAIL swap_ldR got n=%0d %0d:%h %0d:%h exp 2 1:2222 2:1111",
                           obs_nld, obs_id[0], obs_val[0], obs_id[1], obs_val[1]); end
      tests++; if (!obs_done || obs_resp !== 2'b10 || obs_rdata !== 16'h1111) begin
         fails++; $display("FAIL swap_resp got %b %h exp 10 1111", obs_resp, obs_rdata); end
      run_op(1'b0, 2'b00, 3'd1, 3'd0, 16'h0);
      tests++; if (obs_rdata !== 16'h2222) begin fails++; $display("FAIL swap_rd1 got %h exp 2222", obs_rdata); end
      run_op(1'b1, 2'b00, 3'd2, 3'd0, 16'h0);
      tests++; if (obs_rdata !== 16'h1111) begin fails++; $display("FAIL swap_rd2 got %h exp 1111", obs_rdata); end
   endtask

   task automatic test_move_same;
      logic [DW-1:0] e;
      run_op(1'b0, 2'b01, 3'd5, 3'd0, 16'h00A5); model_op(2'b01, 3'd5, 3'd0, 16'h00A5, e);
      run_op(1'b0, 2'b10, 3'd5, 3'd5, 16'h0);    model_op(2'b10, 3'd5, 3'd5, 16'h0, e);
      tests++; if (obs_nld != 1 || obs_val[0] !== 16'h00A5 || obs_id[0] !== 3'd5) begin
         fails++; $display("FAIL mv55_ldR got n=%0d %0d:%h exp 1 5:00a5", obs_nld, obs_id[0], obs_val[0]); end
      tests++; if (!obs_done || obs_rdata !== 16'h00A5 || obs_lat != 2) begin
         fails++; $display("FAIL mv55_resp got %h lat=%0d exp 00a5 2", obs_rdata, obs_lat); end
      run_op(1'b1, 2'b00, 3'd5, 3'd0, 16'h0);
      tests++; if (obs_rdata !== 16'h00A5) begin fails++; $display("FAIL mv55_rd got %h exp 00a5", obs_rdata); end
   endtask

   task automatic test_rr;
      int grants, gap, last_cyc, cyc;
      logic exp_last, g;
      logic [DW-1:0] e;
      @(negedge clk); reset = 1'b0; @(negedge clk); reset = 1'b1;
      exp_last = 1'b1;
      grants = 0; last_cyc = -1; cyc = 0;
      set_req(1'b0, 2'b01, 3'd4, 3'd0, 16'hAAAA);
      set_req(1'b1, 2'b01, 3'd6, 3'd0, 16'h5555);
      req_valid = 2'b11;
      while (grants < 6 && cyc < 40) begin
         if (req_ready != 2'b00) begin
            g = req_ready[1];
            tests++; if (req_ready !== 2'b01 && req_ready !== 2'b10) begin
               fails++; $display("FAIL rr_onehot got %b exp one bit", req_ready); end
            tests++; if (g !== ~exp_last) begin
               fails++; $display("FAIL rr_grant#%0d got %0d exp %0d", grants, g, ~exp_last); end
            if (last_cyc >= 0) begin
               gap = cyc - last_cyc;
               tests++; if (gap != 2) begin fails++; $display("FAIL rr_gap got %0d exp 2", gap); end
            end
            exp_last = g;
            last_cyc = cyc;
            grants++;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = 2'b00;
      tests++; if (grants != 6) begin fails++; $display("FAIL rr_count got %0d exp 6", grants); end
      repeat (4) @(negedge clk);
      model_op(2'b01, 3'd4, 3'd0, 16'hAAAA, e);
      model_op(2'b01, 3'd6, 3'd0, 16'h5555, e);
   endtask

   task automatic test_reset_mid;
      logic [DW-1:0] e;
      logic bad;
      int n;
      run_op(1'b0, 2'b01, 3'd6, 3'd0, 16'h6666); model_op(2'b01, 3'd6, 3'd0, 16'h6666, e);
      run_op(1'b1, 2'b01, 3'd7, 3'd0, 16'h7777); model_op(2'b01, 3'd7, 3'd0, 16'h7777, e);
      @(negedge clk);
      set_req(1'b0, 2'b11, 3'd6, 3'd7, 16'h0);
      req_valid = 2'b01;
      n = 0;
      while (!req_ready[0] && n < 10) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      tests++; if (busy !== 1'b1 || ldR !== 1'b0) begin fails++; $display("FAIL rstmid_pre got busy=%b ldR=%b exp 1 0", busy, ldR); end
      reset = 1'b0;
      @(negedge clk);
      tests++; if (ldR !== 1'b0 || resp_valid !== 2'b00 || busy !== 1'b0) begin
         fails++; $display("FAIL rstmid_abort got ldR=%b resp=%b busy=%b exp 0 00 0", ldR, resp_valid, busy); end
      reset = 1'b1;
      bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ldR !== 1'b0 || resp_valid !== 2'b00) bad = 1'b1;
      end
      tests++; if (bad) begin fails++; $display("FAIL rstmid_quiet got late ldR/resp exp none"); end
      tests++; if (bank[6] !== model[6] || bank[7] !== model[7]) begin
         fails++; $display("FAIL rstmid_bank got %h %h exp %h %h", bank[6], bank[7], model[6], model[7]); end
   endtask

   task automatic test_busy_hold;
      logic [DW-1:0] e_sw, e_rd;
      logic bad;
      int n;
      @(negedge clk);
      set_req(1'b1, 2'b11, 3'd0, 3'd1, 16'h0);
      req_valid = 2'b10;
      n = 0;
      while (!req_ready[1] && n < 10) begin @(negedge clk); n++; end
      @(negedge clk);
      set_req(1'b0, 2'b00, 3'd2, 3'd0, 16'h0);
      scramble(1'b1);
      req_valid = 2'b01;
      bad = 1'b0;
      n = 0;
      while (busy && n < 10) begin
         if (req_ready !== 2'b00) bad = 1'b1;
         @(negedge clk);
         n++;
      end
      model_op(2'b11, 3'd0, 3'd1, 16'h0, e_sw);
      tests++; if (bad || n != 4) begin fails++; $display("FAIL hold_ready got early ready=%b busy_cycles=%0d exp 0 4", bad, n); end
      tests++; if (resp_valid !== 2'b10 || req_ready !== 2'b01 || resp_rdata !== e_sw) begin
         fails++; $display("FAIL hold_handoff got resp=%b ready=%b data=%h exp 10 01 %h", resp_valid, req_ready, resp_rdata, e_sw); end
      @(negedge clk);
      req_valid = 2'b00;
      scramble(1'b0);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_accept got busy=%b exp 1", busy); end
      model_op(2'b00, 3'd2, 3'd0, 16'h0, e_rd);
      @(negedge clk);
      tests++; if (resp_valid !== 2'b01 || resp_rdata !== e_rd) begin
         fails++; $display("FAIL hold_read got %b %h exp 01 %h", resp_valid, resp_rdata, e_rd); end
   endtask

   task automatic test_random;
      logic          k;
      logic [1:0]    op;
      logic [IW-1:0] ra, rb;
      logic [DW-1:0] wd, e;
      for (int i = 0; i < 40; i++) begin
         k  = 1'($urandom_range(1));
         op = 2'($urandom_range(3));
         ra = 3'($urandom_range(7));
         rb = 3'($urandom_range(7));
         wd = 16'($urandom);
         run_op(k, op, ra, rb, wd);
         model_op(op, ra, rb, wd, e);
         tests++; if (!obs_done || obs_resp !== (k ? 2'b10 : 2'b01) || obs_rdata !== e) begin
            fails++; $display("FAIL rand#%0d op=%0d ra=%0d rb=%0d got resp=%b data=%h exp port=%0d data=%h",
                              i, op, ra, rb, obs_resp, obs_rdata, k, e); end
         tests++; if (obs_lat != lat_tab[op] || obs_nld != ld_tab[op] || !obs_idle_ok) begin
            fails++; $display("FAIL rand_seq#%0d op=%0d got lat=%0d ld=%0d idle_ok=%b exp %0d %0d 1",
                              i, op, obs_lat, obs_nld, obs_idle_ok, lat_tab[op], ld_tab[op]); end
      end
      for (int i = 0; i < 8; i++) begin
         tests++; if (bank[i] !== model[i]) begin
            fails++; $display("FAIL rand_bank r%0d got %h exp %h", i, bank[i], model[i]); end
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         bank[i]  = '0;
         model[i] = '0;
      end
      test_reset();
      test_write_read();
      test_swap();
      test_move_same();
      test_rr();
      test_reset_mid();
      test_busy_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got no finish exp finish");
      $fatal(1, "watchdog");
   end

endmodule
